// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit counter branch predictor with redirect/flush sequencing
// Optional feature macro: BPU_STATS_EN (resolved-branch and mispredict counters)
module branch_predict_ctrl #(
   parameter int         IDX_BITS    = 4,
   parameter int         FLUSH_DEPTH = 2,
   parameter logic [1:0] CTR_INIT    = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_is_branch,
   input  logic [31:0] id_pc,
   input  logic [11:0] id_imm_B,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_pred_taken,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int         ENTRIES        = 2 ** IDX_BITS;
   localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [3:0]    flush_cnt_q;
   logic [3:0]    flush_cnt_d;
   logic          redirect_valid_d;
   logic [31:0]   redirect_pc_d;
   logic [1:0]    ctr_table [ENTRIES];
   logic [IDX_BITS-1:0] id_idx;
   logic [IDX_BITS-1:0] ex_idx;
   logic          resolve;
   logic          mispredict;
   logic [1:0]    ex_ctr;
   logic [1:0]    ex_ctr_next;

   assign id_idx = id_pc[IDX_BITS+1:2];
   assign ex_idx = ex_pc[IDX_BITS+1:2];

   // Branches seen while flushing are on the wrong path and are ignored.
   assign resolve    = ex_valid & ex_is_branch & (state_q == IDLE);
   assign mispredict = resolve & (ex_taken != ex_pred_taken);

   // Prediction reads the table before any same-cycle update lands.
   always_comb begin
      pred_taken  = id_valid & id_is_branch & ctr_table[id_idx][1];
      pred_target = id_pc + {{19{id_imm_B[11]}}, id_imm_B, 1'b0};
   end

   // Saturating increment/decrement of the counter being trained.
   always_comb begin
      ex_ctr      = ctr_table[ex_idx];
      ex_ctr_next = ex_ctr;
      if (ex_taken) begin
         if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'b01;
      end else begin
         if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'b01;
      end
   end

   // Counter table: reset to CTR_INIT, trained on each resolve event.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
      end else if (resolve) begin
         ctr_table[ex_idx] <= ex_ctr_next;
      end
   end

   // Next-state and redirect decode for the redirect/flush sequencer.
   always_comb begin
      state_d          = state_q;
      flush_cnt_d      = flush_cnt_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d          = FLUSH;
               flush_cnt_d      = FLUSH_CNT_INIT;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = ex_taken ? ex_target : (ex_pc + 32'd4);
            end
         end
         FLUSH: begin
            if (flush_cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, flush counter and registered redirect outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         flush_cnt_q    <= 4'd0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         state_q        <= state_d;
         flush_cnt_q    <= flush_cnt_d;
         redirect_valid <= redirect_valid_d;
         redirect_pc    <= redirect_pc_d;
      end
   end

   assign flush = (state_q == FLUSH);

`ifdef BPU_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   // Statistics: count right-path resolves and mispredicts, wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         if (resolve)    branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`else
   assign branch_cnt  = 32'd0;
   assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed self-checking bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic        id_is_branch;
   logic [31:0] id_pc;
   logic [11:0] id_imm_B;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_pred_taken;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int tests_run;
   int tests_failed;

   branch_predict_ctrl #(
      .IDX_BITS   (4),
      .FLUSH_DEPTH(2),
      .CTR_INIT   (2'b01)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_is_branch  (id_is_branch),
      .id_pc         (id_pc),
      .id_imm_B      (id_imm_B),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .ex_valid      (ex_valid),
      .ex_is_branch  (ex_is_branch),
      .ex_pc         (ex_pc),
      .ex_pred_taken (ex_pred_taken),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .flush         (flush),
      .branch_cnt    (branch_cnt),
      .mispred_cnt   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_stats(input string tag, input logic [31:0] b, input logic [31:0] m);
`ifdef BPU_STATS_EN
      check({tag, "_branch_cnt"}, branch_cnt, b);
      check({tag, "_mispred_cnt"}, mispred_cnt, m);
`else
      check({tag, "_branch_cnt"}, branch_cnt, 32'd0 & b);
      check({tag, "_mispred_cnt"}, mispred_cnt, 32'd0 & m);
`endif
   endtask

   task automatic lookup(input logic [31:0] pc);
      id_valid     = 1'b1;
      id_is_branch = 1'b1;
      id_pc        = pc;
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic ptk, input logic [31:0] tgt);
      ex_valid      = 1'b1;
      ex_is_branch  = 1'b1;
      ex_pc         = pc;
      ex_taken      = tk;
      ex_pred_taken = ptk;
      ex_target     = tgt;
   endtask

   task automatic ex_idle();
      ex_valid     = 1'b0;
      ex_is_branch = 1'b0;
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst           = 1'b1;
      id_valid      = 1'b0;
      id_is_branch  = 1'b0;
      id_pc         = 32'd0;
      id_imm_B      = 12'd0;
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_pc         = 32'd0;
      ex_pred_taken = 1'b0;
      ex_taken      = 1'b0;
      ex_target     = 32'd0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check_stats("rst", 32'd0, 32'd0);

      // Prediction after reset: weakly not-taken, forward and backward targets
      id_imm_B = 12'h010;
      lookup(32'h100);
      check("pred_after_rst", {31'd0, pred_taken}, 32'd0);
      check("target_fwd", pred_target, 32'h120);
      id_imm_B = 12'hFFE;
      #1;
      check("target_back", pred_target, 32'h0FC);
      id_imm_B = 12'h800;
      lookup(32'h0000_0010);
      check("target_wrap", pred_target, 32'hFFFF_F010);
      id_valid = 1'b0;
      #1;
      check("pred_id_invalid", {31'd0, pred_taken}, 32'd0);
      check("target_id_invalid", pred_target, 32'hFFFF_F010);

      // Taken mispredict at cycle N, wrong-path mispredict at N+1
      id_imm_B = 12'h010;
      resolve(32'h100, 1'b1, 1'b0, 32'h120);
      step();
      check("tk_rv_n1", {31'd0, redirect_valid}, 32'd1);
      check("tk_rpc_n1", redirect_pc, 32'h120);
      check("tk_flush_n1", {31'd0, flush}, 32'd1);
      resolve(32'h100, 1'b0, 1'b1, 32'h0);
      step();
      ex_idle();
      check("tk_rv_n2", {31'd0, redirect_valid}, 32'd0);
      check("tk_rpc_hold", redirect_pc, 32'h120);
      check("tk_flush_n2", {31'd0, flush}, 32'd1);
      step();
      check("tk_flush_n3", {31'd0, flush}, 32'd0);
      check("tk_rv_n3", {31'd0, redirect_valid}, 32'd0);
      lookup(32'h100);
      check("tk_pred_after", {31'd0, pred_taken}, 32'd1);
      check_stats("tk", 32'd1, 32'd1);

      // Not-taken mispredict on 0x200 (shares index 0): bring to 11 first
      resolve(32'h200, 1'b1, 1'b1, 32'h280);
      step();
      check("nt_correct_no_rv", {31'd0, redirect_valid}, 32'd0);
      check("nt_correct_no_flush", {31'd0, flush}, 32'd0);
      resolve(32'h200, 1'b0, 1'b1, 32'h280);
      step();
      ex_idle();
      check("nt_rv", {31'd0, redirect_valid}, 32'd1);
      check("nt_rpc", redirect_pc, 32'h204);
      check("nt_flush", {31'd0, flush}, 32'd1);
      lookup(32'h200);
      check("nt_pred_ctr10", {31'd0, pred_taken}, 32'd1);
      step();
      step();
      check("nt_flush_done", {31'd0, flush}, 32'd0);
      resolve(32'h200, 1'b0, 1'b0, 32'h280);
      step();
      ex_idle();
      lookup(32'h200);
      check("nt_pred_ctr01", {31'd0, pred_taken}, 32'd0);
      check_stats("nt", 32'd4, 32'd2);

      // Saturation on index 1 and aliasing of 0x184
      for (int i = 0; i < 4; i++) begin
         resolve(32'h144, 1'b1, 1'b1, 32'h1C0);
         step();
         check($sformatf("sat_no_rv_%0d", i), {30'd0, flush, redirect_valid}, 32'd0);
      end
      resolve(32'h144, 1'b0, 1'b0, 32'h1C0);
      step();
      ex_idle();
      lookup(32'h144);
      check("sat_pred_ctr10", {31'd0, pred_taken}, 32'd1);
      lookup(32'h184);
      check("alias_pred", {31'd0, pred_taken}, 32'd1);
      resolve(32'h144, 1'b0, 1'b0, 32'h1C0);
      step();
      ex_idle();
      lookup(32'h144);
      check("sat_pred_ctr01", {31'd0, pred_taken}, 32'd0);
      check_stats("sat", 32'd10, 32'd2);

      // Same-cycle lookup and update of index 0 (counter 01 -> 10)
      lookup(32'h300);
      resolve(32'h100, 1'b1, 1'b1, 32'h120);
      #1;
      check("coll_pred_old", {31'd0, pred_taken}, 32'd0);
      step();
      ex_idle();
      #1;
      check("coll_pred_new", {31'd0, pred_taken}, 32'd1);
      check_stats("coll", 32'd11, 32'd2);

      // Reset in the middle of a flush
      resolve(32'h144, 1'b1, 1'b0, 32'h1C0);
      step();
      ex_idle();
      check("mid_flush_on", {31'd0, flush}, 32'd1);
      check_stats("mid", 32'd12, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_flush", {31'd0, flush}, 32'd0);
      check("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
      check("mid_rst_rpc", redirect_pc, 32'd0);
      check_stats("mid_rst", 32'd0, 32'd0);
      lookup(32'h300);
      check("mid_rst_tbl0", {31'd0, pred_taken}, 32'd0);
      lookup(32'h144);
      check("mid_rst_tbl1", {31'd0, pred_taken}, 32'd0);
      step();
      check("mid_rst_stays_idle", {31'd0, flush}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch control unit for the pipelined RV32 core. It predicts conditional branches in ID using a direct-mapped table of 2-bit saturating counters. It computes the predicted target as pc + (sext(imm_B) << 1). It resolves predictions against the EX-stage outcome and sequences the redirect/flush of wrong-path instructions.

Parameters:
IDX_BITS, 4, table index width; ENTRIES = 2**IDX_BITS; index = pc[IDX_BITS+1:2]
FLUSH_DEPTH, 2, cycles flush is held after a redirect (number of wrong-path slots in flight); legal range 1..15
CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
id_valid  in  1  ID stage holds a valid instruction
id_is_branch  in  1  ID instruction is a conditional branch
id_pc  in  32  PC of ID instruction
id_imm_B  in  12  B-type immediate (offset bits [12:1])
pred_taken  out  1  combinational prediction for ID instruction
pred_target  out  32  combinational predicted target
ex_valid  in  1  EX stage holds a valid instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_pc  in  32  PC of EX branch
ex_pred_taken  in  1  prediction carried down the pipe with the EX branch
ex_taken  in  1  actual outcome
ex_target  in  32  actual taken target
redirect_valid  out  1  registered one-cycle redirect strobe
redirect_pc  out  32  registered redirect address
flush  out  1  kill younger instructions in IF/ID
branch_cnt  out  32  resolved-branch count (optional feature)
mispred_cnt  out  32  mispredict count (optional feature)

Behaviour:
- Reset, synchronous: every table entry = CTR_INIT; state = IDLE; redirect_valid = 0; redirect_pc = 0; flush = 0; flush counter = 0; branch_cnt = mispred_cnt = 0. Reset mid-FLUSH aborts the flush immediately (flush = 0 on the next cycle).
- Prediction, combinational, 0 cycles:
  - pred_taken = id_valid & id_is_branch & table[idx(id_pc)][1].
  - pred_target = id_pc + ({{19{imm[11]}}, imm, 1'b0}), computed mod 2^32 (wraps; no overflow flag).
  - When id_valid = 0 or id_is_branch = 0: pred_taken = 0, and pred_target still reflects the computation.
- Resolve event: ex_valid & ex_is_branch & (state == IDLE).
  - Events occurring in FLUSH are wrong-path: no table update, no redirect, not counted.
- Table update on a resolve event, at the next edge:
  - ex_taken = 1: counter increments, saturating at 2'b11.
  - ex_taken = 0: counter decrements, saturating at 2'b00.
  - Index = idx(ex_pc).
- Same-cycle ID lookup and EX update to the same index: the lookup sees the old value (read-before-write).
- Mispredict = resolve event & (ex_taken != ex_pred_taken).
- FSM IDLE -> FLUSH on a mispredict at cycle N. At cycle N+1:
  - redirect_valid = 1 for exactly one cycle;
  - redirect_pc = ex_target if ex_taken, else ex_pc + 4;
  - flush = 1;
  - counter loads FLUSH_DEPTH-1.
- FSM FLUSH: flush = 1.
  - Counter decrements each cycle; FLUSH -> IDLE when counter == 0.
  - flush is therefore high for exactly FLUSH_DEPTH cycles (N+1 .. N+FLUSH_DEPTH).
- redirect_pc holds its last value when redirect_valid = 0.
- A correct prediction produces no redirect and no flush.

Optional Feature:
BPU_STATS_EN
- Defined:
  - branch_cnt increments on every resolve event.
  - mispred_cnt increments on every mispredict.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: both ports remain present and are tied to 0; no counter flops are built.

Test Plan:
- Prediction after reset: rst, then id_valid = 1, id_is_branch = 1, id_pc = 0x100, imm_B = 0x010 -> pred_taken = 0, pred_target = 0x120. imm_B = 0xFFE -> pred_target = 0x0FC.
- Taken mispredict, FLUSH_DEPTH = 2: resolve ex_pc = 0x100, ex_taken = 1, ex_pred_taken = 0, ex_target = 0x120 at cycle N.
  - redirect_valid = 1 with redirect_pc = 0x120 at N+1 only.
  - flush = 1 at N+1 and N+2, 0 at N+3.
  - Lookup of id_pc = 0x100 then gives pred_taken = 1 (counter 2'b10).
- Wrong-path suppression: a mispredicting resolve at N+1 (inside FLUSH) -> no second redirect, table entry unchanged, mispred_cnt unchanged.
- Not-taken mispredict: entry for 0x200 at 2'b11; resolve ex_pc = 0x200, ex_taken = 0, ex_pred_taken = 1 -> redirect_pc = 0x204; counter becomes 2'b10.
- Saturation and aliasing, ex_pc = 0x144 (index 1):
  - 4 correctly predicted taken resolves -> counter 2'b11, no redirect.
  - One not-taken -> 2'b10, pred_taken still 1.
  - With IDX_BITS = 4, id_pc = 0x184 aliases to index 1 and also predicts taken.
- Same-index collision and stats with BPU_STATS_EN:
  - ID lookup and EX update of index 0 in the same cycle -> pred_taken reflects the pre-update counter.
  - After the above sequence, branch_cnt and mispred_cnt equal the number of non-flushed resolves and mispredicts.
  - rst mid-flush clears flush, counters and table.
